// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: rounding modes, round/pack states, IEEE-754 single-precision limits.
package fpu_pkg;

  localparam int OPERAND_WIDTH  = 32;
  localparam int EXPONENT_WIDTH = 8;
  localparam int FRACTION_WIDTH = 23;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rnd_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    PACK  = 2'd2,
    HOLD  = 2'd3
  } round_state_e;

  localparam logic [EXPONENT_WIDTH-1:0] EXP_MAX    = 8'hFF;
  localparam logic [OPERAND_WIDTH-1:0]  POS_INF    = 32'h7F800000;
  localparam logic [OPERAND_WIDTH-2:0]  MAX_FINITE = 31'h7F7FFFFF;

  // Encodings 5-7 are reserved and fall back to round-to-nearest-even.
  function automatic rnd_mode_e decode_mode(input logic [2:0] mode);
    case (mode)
      3'd1:    return RTZ;
      3'd2:    return RDN;
      3'd3:    return RUP;
      3'd4:    return RMM;
      default: return RNE;
    endcase
  endfunction

endpackage

// File: rtl/fround_inc.sv
// Rounding-increment decision for one significand, shared by the mul/div and add/sub back-ends.
module fround_inc
  import fpu_pkg::*;
(
  input  logic       sign_i,
  input  logic       lsb_i,
  input  logic [2:0] grs_i,
  input  logic [2:0] mode_i,
  output logic       inc_o,
  output logic       nx_o
);

  logic g, r, s;

  assign g    = grs_i[2];
  assign r    = grs_i[1];
  assign s    = grs_i[0];
  assign nx_o = |grs_i;

  always_comb begin
    inc_o = 1'b0;
    case (decode_mode(mode_i))
      RNE:     inc_o = g & (r | s | lsb_i);
      RTZ:     inc_o = 1'b0;
      RDN:     inc_o = sign_i & (g | r | s);
      RUP:     inc_o = ~sign_i & (g | r | s);
      RMM:     inc_o = g;
      default: inc_o = g & (r | s | lsb_i);
    endcase
  end

endmodule

// File: rtl/fround_pack.sv
// Round-and-pack back-end: captures an unpacked result, rounds it, packs an IEEE-754 word
// with OF/UF/NX flags and holds it on a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a rising edge of rnd_valid_i
// ROUND | rounding increment applied to the captured fraction
// PACK  | carry, overflow and underflow resolved, result registered
// HOLD  | result presented until rnd_ready_i is sampled high
module fround_pack
  import fpu_pkg::*;
(
  input  logic                      fpu_clk,
  input  logic                      fpu_rst,
  input  logic                      rnd_valid_i,
  input  logic                      rnd_sign_i,
  input  logic [EXPONENT_WIDTH-1:0] rnd_exp_i,
  input  logic [FRACTION_WIDTH-1:0] rnd_frac_i,
  input  logic [2:0]                rnd_grs_i,
  input  logic                      rnd_exp_ovf_i,
  input  logic [2:0]                rnd_mode_i,
  input  logic                      rnd_ready_i,
  output logic [OPERAND_WIDTH-1:0]  rnd_result_o,
  output logic                      rnd_valid_o,
  output logic                      rnd_of_o,
  output logic                      rnd_uf_o,
  output logic                      rnd_nx_o,
  output logic                      rnd_busy_o,
  output logic                      rnd_lost_o
);

  round_state_e state_q, state_d;

  logic                      valid_prev_q;
  logic                      start;
  logic                      sign_q;
  logic [EXPONENT_WIDTH-1:0] exp_q;
  logic [FRACTION_WIDTH-1:0] frac_q;
  logic [2:0]                grs_q;
  logic                      ovf_q;
  logic [2:0]                mode_q;
  logic [FRACTION_WIDTH:0]   sum_q;
  logic                      nx_q;

  logic                      inc;
  logic                      nx_rnd;
  logic                      carry;
  logic [EXPONENT_WIDTH-1:0] exp_out;
  logic [FRACTION_WIDTH-1:0] frac_out;
  logic                      ovf;
  logic [OPERAND_WIDTH-1:0]  result_d;
  logic                      of_d, uf_d, nx_d;

  assign start = rnd_valid_i & ~valid_prev_q;

  fround_inc u_inc (
    .sign_i (sign_q),
    .lsb_i  (frac_q[0]),
    .grs_i  (grs_q),
    .mode_i (mode_q),
    .inc_o  (inc),
    .nx_o   (nx_rnd)
  );

  always_ff @(posedge fpu_clk or posedge fpu_rst) begin
    if (fpu_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ROUND;
      ROUND:   state_d = PACK;
      PACK:    state_d = HOLD;
      HOLD:    if (rnd_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pack: fold the significand carry into the exponent, then resolve overflow by mode.
  always_comb begin
    carry    = sum_q[FRACTION_WIDTH];
    frac_out = carry ? '0 : sum_q[FRACTION_WIDTH-1:0];
    exp_out  = exp_q + {{(EXPONENT_WIDTH-1){1'b0}}, carry};
    ovf      = ovf_q | (exp_q == EXP_MAX) | (exp_out == EXP_MAX);
    result_d = {sign_q, exp_out, frac_out};
    of_d     = ovf;
    nx_d     = nx_q | ovf;
    uf_d     = (exp_out == '0) & nx_q & ~ovf;
    if (ovf) begin
      case (decode_mode(mode_q))
        RTZ:     result_d = {sign_q, MAX_FINITE};
        RDN:     result_d = sign_q ? {1'b1, POS_INF[OPERAND_WIDTH-2:0]} : {1'b0, MAX_FINITE};
        RUP:     result_d = sign_q ? {1'b1, MAX_FINITE} : {1'b0, POS_INF[OPERAND_WIDTH-2:0]};
        default: result_d = {sign_q, POS_INF[OPERAND_WIDTH-2:0]};
      endcase
    end
  end

  always_ff @(posedge fpu_clk or posedge fpu_rst) begin
    if (fpu_rst) begin
      valid_prev_q <= 1'b0;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      frac_q       <= '0;
      grs_q        <= '0;
      ovf_q        <= 1'b0;
      mode_q       <= '0;
      sum_q        <= '0;
      nx_q         <= 1'b0;
      rnd_result_o <= '0;
      rnd_of_o     <= 1'b0;
      rnd_uf_o     <= 1'b0;
      rnd_nx_o     <= 1'b0;
      rnd_valid_o  <= 1'b0;
      rnd_busy_o   <= 1'b0;
      rnd_lost_o   <= 1'b0;
    end else begin
      valid_prev_q <= rnd_valid_i;
      rnd_valid_o  <= (state_d == HOLD);
      rnd_busy_o   <= (state_d != IDLE);
      if (start && state_q != IDLE) rnd_lost_o <= 1'b1;
      if (state_q == IDLE && start) begin
        sign_q <= rnd_sign_i;
        exp_q  <= rnd_exp_i;
        frac_q <= rnd_frac_i;
        grs_q  <= rnd_grs_i;
        ovf_q  <= rnd_exp_ovf_i;
        mode_q <= rnd_mode_i;
      end
      if (state_q == ROUND) begin
        sum_q <= {1'b0, frac_q} + {{FRACTION_WIDTH{1'b0}}, inc};
        nx_q  <= nx_rnd;
      end
      if (state_q == PACK) begin
        rnd_result_o <= result_d;
        rnd_of_o     <= of_d;
        rnd_uf_o     <= uf_d;
        rnd_nx_o     <= nx_d;
      end
    end
  end

endmodule

// File: tb/tb_fround_pack.sv
// Directed bench for fround_pack: rounding vectors with hand-computed words, handshake and reset cases.
module tb_fround_pack;
  import fpu_pkg::*;

  logic        fpu_clk = 1'b0;
  logic        fpu_rst;
  logic        rnd_valid_i;
  logic        rnd_sign_i;
  logic [7:0]  rnd_exp_i;
  logic [22:0] rnd_frac_i;
  logic [2:0]  rnd_grs_i;
  logic        rnd_exp_ovf_i;
  logic [2:0]  rnd_mode_i;
  logic        rnd_ready_i;
  logic [31:0] rnd_result_o;
  logic        rnd_valid_o, rnd_of_o, rnd_uf_o, rnd_nx_o, rnd_busy_o, rnd_lost_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 fpu_clk = ~fpu_clk;

  fround_pack dut (
    .fpu_clk       (fpu_clk),
    .fpu_rst       (fpu_rst),
    .rnd_valid_i   (rnd_valid_i),
    .rnd_sign_i    (rnd_sign_i),
    .rnd_exp_i     (rnd_exp_i),
    .rnd_frac_i    (rnd_frac_i),
    .rnd_grs_i     (rnd_grs_i),
    .rnd_exp_ovf_i (rnd_exp_ovf_i),
    .rnd_mode_i    (rnd_mode_i),
    .rnd_ready_i   (rnd_ready_i),
    .rnd_result_o  (rnd_result_o),
    .rnd_valid_o   (rnd_valid_o),
    .rnd_of_o      (rnd_of_o),
    .rnd_uf_o      (rnd_uf_o),
    .rnd_nx_o      (rnd_nx_o),
    .rnd_busy_o    (rnd_busy_o),
    .rnd_lost_o    (rnd_lost_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [22:0] f,
                       input logic [2:0] g, input logic [2:0] m, input logic ov);
    rnd_sign_i    = s;
    rnd_exp_i     = e;
    rnd_frac_i    = f;
    rnd_grs_i     = g;
    rnd_mode_i    = m;
    rnd_exp_ovf_i = ov;
  endtask

  // Single-cycle valid pulse; returns at the negedge after the capture edge.
  task automatic send(input logic s, input logic [7:0] e, input logic [22:0] f,
                      input logic [2:0] g, input logic [2:0] m, input logic ov);
    @(negedge fpu_clk);
    drive(s, e, f, g, m, ov);
    rnd_valid_i = 1'b1;
    @(posedge fpu_clk);
    @(negedge fpu_clk);
    rnd_valid_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int edges = 0;
    while (!rnd_valid_o && edges < 10) begin
      @(posedge fpu_clk);
      #1;
      edges++;
    end
    check({tag, "_lat"}, edges, 2);
  endtask

  task automatic txn(input string tag, input logic s, input logic [7:0] e, input logic [22:0] f,
                     input logic [2:0] g, input logic [2:0] m, input logic ov,
                     input logic [31:0] exp_res, input logic [2:0] exp_flags);
    send(s, e, f, g, m, ov);
    wait_valid(tag);
    check({tag, "_res"}, rnd_result_o, exp_res);
    check({tag, "_flags"}, {29'd0, rnd_of_o, rnd_uf_o, rnd_nx_o}, {29'd0, exp_flags});
    @(posedge fpu_clk);
    #1;
    check({tag, "_done"}, {31'd0, rnd_valid_o}, 32'd0);
  endtask

  initial begin
    int cnt;
    fpu_rst     = 1'b1;
    rnd_valid_i = 1'b0;
    rnd_ready_i = 1'b1;
    drive(1'b0, 8'h00, 23'h0, 3'b000, 3'd0, 1'b0);
    repeat (3) @(posedge fpu_clk);
    #1;
    check("reset_outs", {rnd_result_o[31:0]}, 32'h0);
    check("reset_ctl", {26'd0, rnd_valid_o, rnd_of_o, rnd_uf_o, rnd_nx_o, rnd_busy_o, rnd_lost_o}, 32'h0);
    @(negedge fpu_clk);
    fpu_rst = 1'b0;

    //   tag           sign exp    frac        grs     mode ovf  result        {of,uf,nx}
    txn("rne_tie_odd",  0, 8'h7F, 23'h000001, 3'b100, 3'd0, 0, 32'h3F800002, 3'b001);
    txn("rne_tie_even", 0, 8'h7F, 23'h000000, 3'b100, 3'd0, 0, 32'h3F800000, 3'b001);
    txn("rne_carry",    0, 8'h7F, 23'h7FFFFF, 3'b110, 3'd0, 0, 32'h40000000, 3'b001);
    txn("ovf_rne",      0, 8'hFE, 23'h7FFFFF, 3'b100, 3'd0, 0, 32'h7F800000, 3'b101);
    txn("ovf_rtz",      0, 8'hFE, 23'h7FFFFF, 3'b100, 3'd1, 0, 32'h7F7FFFFF, 3'b001);
    txn("ovf_rup_neg",  1, 8'hFE, 23'h7FFFFF, 3'b100, 3'd3, 0, 32'hFF7FFFFF, 3'b001);
    txn("sub_rup",      0, 8'h00, 23'h7FFFFF, 3'b001, 3'd3, 0, 32'h00800000, 3'b001);
    txn("sub_rtz",      0, 8'h00, 23'h7FFFFF, 3'b001, 3'd1, 0, 32'h007FFFFF, 3'b011);
    txn("flag_ovf_rtz", 0, 8'h80, 23'h000000, 3'b000, 3'd1, 1, 32'h7F7FFFFF, 3'b101);
    txn("flag_ovf_rdn", 1, 8'h80, 23'h000000, 3'b000, 3'd2, 1, 32'hFF800000, 3'b101);
    txn("ovf_rup_pos",  0, 8'hFF, 23'h000000, 3'b000, 3'd3, 0, 32'h7F800000, 3'b101);
    txn("exact",        0, 8'h7F, 23'h123456, 3'b000, 3'd0, 0, 32'h3F923456, 3'b000);
    txn("mode7_rne",    0, 8'h7F, 23'h000001, 3'b110, 3'd7, 0, 32'h3F800002, 3'b001);
    txn("rmm_tie",      0, 8'h7F, 23'h000000, 3'b100, 3'd4, 0, 32'h3F800001, 3'b001);
    txn("rdn_pos",      0, 8'h7F, 23'h000001, 3'b011, 3'd2, 0, 32'h3F800001, 3'b001);
    txn("rdn_neg",      1, 8'h7F, 23'h000001, 3'b011, 3'd2, 0, 32'hBF800002, 3'b001);

    // Level-held valid for four cycles yields one result and no drop.
    @(negedge fpu_clk);
    drive(0, 8'h7F, 23'h000001, 3'b100, 3'd0, 0);
    rnd_valid_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge fpu_clk);
      #1;
      if (i == 3) rnd_valid_i = 1'b0;
      if (rnd_valid_o) cnt++;
    end
    check("held_valid_count", cnt, 1);
    check("held_valid_lost", {31'd0, rnd_lost_o}, 32'd0);

    // Back-pressure with a second rising edge arriving during HOLD.
    rnd_ready_i = 1'b0;
    send(0, 8'h7F, 23'h000001, 3'b100, 3'd0, 0);
    wait_valid("bp");
    drive(1, 8'h01, 23'h555555, 3'b111, 3'd3, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge fpu_clk);
      #1;
      if (i == 1) rnd_valid_i = 1'b1;
      if (i == 2) rnd_valid_i = 1'b0;
      check("bp_valid", {31'd0, rnd_valid_o}, 32'd1);
      check("bp_result", rnd_result_o, 32'h3F800002);
    end
    check("bp_lost", {31'd0, rnd_lost_o}, 32'd1);
    rnd_ready_i = 1'b1;
    @(posedge fpu_clk);
    #1;
    check("bp_release", {31'd0, rnd_valid_o}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge fpu_clk);
      #1;
      if (rnd_valid_o) cnt++;
    end
    check("bp_no_extra", cnt, 0);

    // Reset while in PACK abandons the transaction.
    send(0, 8'h7F, 23'h7FFFFF, 3'b110, 3'd0, 0);
    check("busy_round", {31'd0, rnd_busy_o}, 32'd1);
    @(posedge fpu_clk);
    #1;
    fpu_rst = 1'b1;
    #1;
    check("rst_result", rnd_result_o, 32'h0);
    check("rst_ctl", {26'd0, rnd_valid_o, rnd_of_o, rnd_uf_o, rnd_nx_o, rnd_busy_o, rnd_lost_o}, 32'h0);
    repeat (2) @(posedge fpu_clk);
    @(negedge fpu_clk);
    fpu_rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge fpu_clk);
      #1;
      if (rnd_valid_o) cnt++;
    end
    check("rst_no_pulse", cnt, 0);
    txn("post_rst", 1, 8'h81, 23'h400000, 3'b000, 3'd0, 0, 32'hC0C00000, 3'b000);
    check("post_rst_lost", {31'd0, rnd_lost_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/fround_pack.md
# fround_pack

Rounding and packing back-end for the single-precision FPU datapath. Consumes the unpacked result (sign, biased exponent, 23-bit fraction, guard/round/sticky bits and exponent-overflow flag) from the multiply/divide unit. Applies the selected IEEE-754 rounding mode and handles significand carry, overflow and subnormal/underflow cases. Delivers a packed 32-bit word with exception flags over a valid/ready handshake toward the AXI register layer.

## Interface
- OPERAND_WIDTH, 32: packed result width
- EXPONENT_WIDTH, 8: biased exponent width
- FRACTION_WIDTH, 23: stored fraction width
- Clock and reset: one clock; reset is asynchronous and active-high.
- fpu_clk  in  1  clock
- fpu_rst  in  1  asynchronous reset, active-high
- rnd_valid_i  in  1  upstream result valid, may be level-held for several cycles; driven by the producer's ready output
- rnd_sign_i  in  1  result sign
- rnd_exp_i  in  EXPONENT_WIDTH  biased exponent
- rnd_frac_i  in  FRACTION_WIDTH  fraction before rounding
- rnd_grs_i  in  3  guard, round, sticky, MSB first
- rnd_exp_ovf_i  in  1  upstream exponent overflow
- rnd_mode_i  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5–7 treated as RNE
- rnd_ready_i  in  1  downstream accepts the result
- rnd_result_o  out  OPERAND_WIDTH  packed IEEE-754 word
- rnd_valid_o  out  1  result valid
- rnd_of_o, rnd_uf_o, rnd_nx_o  out  1 each  overflow, underflow and inexact flags, valid with rnd_valid_o
- rnd_busy_o  out  1  block is not IDLE
- rnd_lost_o  out  1  sticky flag: an upstream result was dropped while busy

## Operation
- Edge detect: register valid_prev (reset value 0). Start condition is rnd_valid_i & ~valid_prev. A level-held valid produces exactly one transaction.
- States: IDLE, ROUND, PACK, HOLD.
- IDLE: on start, capture all rnd_*_i inputs including mode, then go to ROUND.
- ROUND: compute inc.
  - RNE: G&(R|S|frac[0])
  - RTZ: 0
  - RDN: sign&(G|R|S)
  - RUP: ~sign&(G|R|S)
  - RMM: G
  - nx = |grs. Register sum = {1'b0,frac}+inc (24 bits). Go to PACK.
- PACK:
  - If sum[23]=1: frac_out=0, exp_out=exp+1. Otherwise frac_out=sum[22:0], exp_out=exp.
  - A carry out of a subnormal (exp=0, frac all ones) naturally yields exp_out=1.
  - Overflow condition: exp_ovf_i, or captured exp=8'hFF, or exp_out=8'hFF. On overflow, of=1 and nx=1, and the result is selected by mode:
    - RNE/RMM: ±Inf
    - RTZ: ±0x7F7FFFFF magnitude
    - RDN: +max finite if positive, -Inf if negative
    - RUP: +Inf if positive, -max finite if negative
  - uf = (exp_out==0) & nx, with tininess detected after rounding.
  - Register result and flags, then go to HOLD.
- HOLD: rnd_valid_o=1. Result and flags are held stable until rnd_ready_i is sampled high, then go to IDLE.
- Start while not IDLE: the transaction is ignored and rnd_lost_o is set. rnd_lost_o is cleared only by reset.
- Reset values: every output is 0, state is IDLE, valid_prev is 0.
- Reset mid-operation: the transaction is abandoned. No output pulse follows reset deassertion.

## Timing
- Capture edge is T. ROUND occupies T+1, PACK occupies T+2, and rnd_valid_o is high from T+3.
- With rnd_ready_i held high, HOLD lasts exactly one cycle. Minimum spacing between accepted transactions is 4 cycles.
- rnd_busy_o is high from T+1 until the cycle after the handshake completes.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared fpu_pkg holds:
  - rnd_mode_e enum (RNE, RTZ, RDN, RUP, RMM)
  - round_state_e enum
  - EXP_MAX = 8'hFF
  - POS_INF = 32'h7F800000
  - MAX_FINITE = 31'h7F7FFFFF
  - width constants
- One combinational sub-module, fround_inc: inputs sign, lsb, grs, mode; outputs inc and nx. It is reusable by the add/sub path.

## Test plan
- RNE tie cases, sign 0, exp 0x7F, grs 100:
  - frac 0x000001 -> result 0x3F800002, nx=1
  - frac 0x000000 -> result 0x3F800000, nx=1
- Carry, RNE: exp 0x7F, frac 0x7FFFFF, grs 110 -> 0x40000000, nx=1, of=0.
- Overflow: exp 0xFE, frac 0x7FFFFF, grs 100:
  - RNE -> 0x7F800000, of=1, nx=1
  - RTZ -> 0x7F7FFFFF
  - sign 1, RUP -> 0xFF7FFFFF
- Subnormal, sign 0, exp 0, frac 0x7FFFFF:
  - grs 001, RUP -> 0x00800000, uf=0
  - grs 001, RTZ -> 0x007FFFFF, uf=1, nx=1
- Handshake:
  - rnd_valid_i held 4 cycles -> exactly one rnd_valid_o.
  - rnd_ready_i low for 5 cycles -> result stable and valid held.
  - Second valid rising edge while busy -> dropped, rnd_lost_o=1.
- Reset asserted in PACK -> all outputs 0. No rnd_valid_o after release until a new rising edge of rnd_valid_i.
